vme_cmd_arbiter: RTL and testbench



---
 rtl/vme_cmd_arbiter_if.sv | 31 +++
 rtl/vme_cmd_arbiter.sv | 175 +++++++++++++++++
 tb/tb_vme_cmd_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vme_cmd_arbiter_if.sv
// Command-port bundle between NREQ requesters, the arbiter and the VME master.
// slave  : arbiter view (requests and VME status in, grants and command out).
// master : environment view (drives requests and VME status, observes outputs).
interface vme_cmd_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_rnw;
  logic [16*NREQ-1:0]   req_addr;
  logic [16*NREQ-1:0]   req_wdata;
  logic [NREQ-1:0]      ack;
  logic [15:0]          rdata;
  logic                 err;
  logic                 busy;
  logic                 vme_cmd_rd;
  logic                 vme_dat_wr;
  logic [31:0]          vme_dat_reg_out;
  logic                 start;
  logic [31:0]          vme_cmd_reg;
  logic [31:0]          vme_dat_reg_in;

  modport slave (
    input  req, req_rnw, req_addr, req_wdata, vme_cmd_rd, vme_dat_wr, vme_dat_reg_out,
    output ack, rdata, err, busy, start, vme_cmd_reg, vme_dat_reg_in
  );

  modport master (
    output req, req_rnw, req_addr, req_wdata, vme_cmd_rd, vme_dat_wr, vme_dat_reg_out,
    input  ack, rdata, err, busy, start, vme_cmd_reg, vme_dat_reg_in
  );
endinterface

// File: rtl/vme_cmd_arbiter.sv
// Round-robin arbiter sharing one VME command port among NREQ command sources.
// Each grant is formatted into vme_cmd_reg/vme_dat_reg_in (MASK plus a
// read/write flag), started with a one-cycle strobe, and completed with a
// one-cycle ack to the winner once the VME master strobes vme_dat_wr.
// Optional WAIT watchdog: define VME_ARB_TIMEOUT_EN to finish a stalled
// transaction after TIMEOUT_CYCLES with err=1 and rdata=16'hDEAD.
module vme_cmd_arbiter #(
  parameter int          NREQ           = 4,
  parameter logic [31:0] MASK           = 32'h00A8_0000,
  parameter int          TIMEOUT_CYCLES = 1023
) (
  input logic              clk,
  input logic              rst,
  vme_cmd_arbiter_if.slave bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Reject configurations the index and watchdog widths cannot represent.
  if ((NREQ < 2) || (NREQ > 8) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 1023)) begin : g_bad_param
    $error("vme_cmd_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES 1..1023");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic              start_r;
  logic              busy_r;
  logic              err_r;
  logic [NREQ-1:0]   ack_r;
  logic [15:0]       rdata_r;
  logic [31:0]       cmd_r;
  logic [31:0]       dat_r;
  logic [IDXW-1:0]   rr_ptr_r;
  logic [IDXW-1:0]   win_r;
  logic              rnw_r;
  logic              pick_valid_s;
  logic [IDXW-1:0]   pick_idx_s;

`ifdef VME_ARB_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0]        wcnt_r;
`endif

  // Command word: MASK over the zero-extended address, bit25 marks a read, bit24 a write.
  function automatic logic [31:0] fmt_cmd(input logic rnw, input logic [15:0] addr);
    logic [31:0] w;
    w = MASK | {16'h0000, addr};
    if (rnw) begin
      w[25] = 1'b1;
    end else begin
      w[24] = 1'b1;
    end
    return w;
  endfunction

  // One-hot ack vector for the winning requester.
  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first active request scanning upward from rr_ptr with wrap.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr_r) + k) % NREQ;
      if (bus.req[idx]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = IDXW'(idx);
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      start_r  <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
      ack_r    <= '0;
      rdata_r  <= 16'h0000;
      cmd_r    <= MASK;
      dat_r    <= 32'h0000_0000;
      rr_ptr_r <= '0;
      win_r    <= '0;
      rnw_r    <= 1'b0;
`ifdef VME_ARB_TIMEOUT_EN
      wcnt_r   <= 10'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= '0;
          if (bus.vme_cmd_rd && pick_valid_s) begin
            win_r   <= pick_idx_s;
            rnw_r   <= bus.req_rnw[pick_idx_s];
            cmd_r   <= fmt_cmd(bus.req_rnw[pick_idx_s], bus.req_addr[16*int'(pick_idx_s) +: 16]);
            dat_r   <= {16'h0000, bus.req_wdata[16*int'(pick_idx_s) +: 16]};
            start_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ISSUE;
          end else begin
            cmd_r   <= MASK;
            dat_r   <= 32'h0000_0000;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          start_r <= 1'b0;
`ifdef VME_ARB_TIMEOUT_EN
          wcnt_r  <= 10'd0;
`endif
          state_r <= WAIT;
        end
        WAIT: begin
          // A completion strobe on the limit cycle still counts as success.
          if (bus.vme_dat_wr) begin
            rdata_r <= rnw_r ? bus.vme_dat_reg_out[15:0] : 16'h0000;
            err_r   <= 1'b0;
            ack_r   <= onehot(win_r);
            state_r <= DONE;
`ifdef VME_ARB_TIMEOUT_EN
          end else if (wcnt_r == TMO_LAST) begin
            rdata_r <= 16'hDEAD;
            err_r   <= 1'b1;
            ack_r   <= onehot(win_r);
            state_r <= DONE;
          end else begin
            wcnt_r  <= wcnt_r + 10'd1;
            state_r <= WAIT;
`else
          end else begin
            state_r <= WAIT;
`endif
          end
        end
        DONE: begin
          ack_r    <= '0;
          busy_r   <= 1'b0;
          cmd_r    <= MASK;
          dat_r    <= 32'h0000_0000;
          rr_ptr_r <= (win_r == IDXW'(NREQ - 1)) ? '0 : (win_r + IDXW'(1));
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.start          = start_r;
  assign bus.busy           = busy_r;
  assign bus.err            = err_r;
  assign bus.ack            = ack_r;
  assign bus.rdata          = rdata_r;
  assign bus.vme_cmd_reg    = cmd_r;
  assign bus.vme_dat_reg_in = dat_r;

endmodule

// File: tb/tb_vme_cmd_arbiter.sv
// Scoreboard bench for vme_cmd_arbiter: the stimulus predicts the grant order
// from the round-robin rule and queues the expected start/ack contents; a
// monitor checks every start and ack against the queue head; a responder
// plays the VME master with random completion delays.
module tb_vme_cmd_arbiter;
  localparam int          NREQ = 4;
  localparam logic [31:0] MASK = 32'h00A8_0000;
  localparam int          TMO  = 16;

  typedef struct {
    logic [31:0]     cmd;
    logic [31:0]     dat;
    logic [NREQ-1:0] ackv;
    logic [15:0]     rdata;
    logic            err;
    logic [31:0]     rdword;
    bit              tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vme_cmd_arbiter_if #(.NREQ(NREQ)) bus ();
  vme_cmd_arbiter #(.NREQ(NREQ), .MASK(MASK), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_cyc = 0;
  int          start_cyc = 0;
  int          model_ptr = 0;
  bit          resp_en = 1'b1;
  int          stray_cnt = 0;
  int          stray_done = 0;
  logic        r_rnw[NREQ];
  logic [15:0] r_addr[NREQ];
  logic [15:0] r_wdata[NREQ];
  logic [31:0] r_rdw[NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] exp_cmd(input logic rnw, input logic [15:0] a);
    return MASK | {16'h0000, a} | (rnw ? 32'h0200_0000 : 32'h0100_0000);
  endfunction

  task automatic fill_rand(input int i);
    r_rnw[i]   = 1'($urandom_range(0, 1));
    r_addr[i]  = 16'($urandom);
    r_wdata[i] = 16'($urandom);
    r_rdw[i]   = $urandom;
  endtask

  task automatic apply_fields();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_rnw[i]             = r_rnw[i];
      bus.req_addr[16*i +: 16]   = r_addr[i];
      bus.req_wdata[16*i +: 16]  = r_wdata[i];
    end
  endtask

  function automatic exp_t make_exp(input int i, input bit tmo);
    exp_t e;
    e.cmd         = exp_cmd(r_rnw[i], r_addr[i]);
    e.dat         = {16'h0000, r_wdata[i]};
    e.ackv        = '0;
    e.ackv[i]     = 1'b1;
    e.rdata       = tmo ? 16'hDEAD : (r_rnw[i] ? r_rdw[i][15:0] : 16'h0000);
    e.err         = tmo;
    e.rdword      = r_rdw[i];
    e.tmo         = tmo;
    return e;
  endfunction

  // Hold the requests in mask until each is acked; expected order comes from the model pointer.
  task automatic run_batch(input logic [NREQ-1:0] mask, input bit tmo);
    int last;
    int budget;
    @(posedge clk); #1;
    last = model_ptr;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (model_ptr + k) % NREQ;
      if (mask[i]) begin
        exp_q.push_back(make_exp(i, tmo));
        last = i;
      end
    end
    model_ptr = (last + 1) % NREQ;
    apply_fields();
    bus.req = mask;
    budget = 400;
    while (bus.req != '0 && budget > 0) begin
      @(negedge clk);
      bus.req = bus.req & ~bus.ack;
      budget--;
    end
    chk("batch_all_acked", 32'(bus.req), 32'd0);
    @(negedge clk);
    chk("batch_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compare every start and ack against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (bus.start === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_start", 32'(bus.start), 32'd0);
          end else begin
            chk("start_cmd", bus.vme_cmd_reg, exp_q[0].cmd);
            chk("start_dat", bus.vme_dat_reg_in, exp_q[0].dat);
            start_cyc = cyc;
          end
        end
        if (bus.ack !== '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(bus.ack), 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("ack_vec", 32'(bus.ack), 32'(mon_e.ackv));
            chk("ack_rdata", 32'(bus.rdata), 32'(mon_e.rdata));
            chk("ack_err", 32'(bus.err), 32'(mon_e.err));
            if (mon_e.tmo) chk("timeout_latency", 32'(cyc - start_cyc), 32'(TMO + 1));
            else           chk("ack_latency", 32'(cyc - wr_cyc), 32'd1);
          end
        end
      end
    end
  end

  // VME master model: completes each start after 1..4 cycles; also issues requested stray strobes.
  initial begin
    bus.vme_dat_wr      = 1'b0;
    bus.vme_dat_reg_out = 32'h0;
    forever begin
      @(negedge clk);
      if (stray_done < stray_cnt) begin
        @(posedge clk); #1;
        bus.vme_dat_wr      = 1'b1;
        bus.vme_dat_reg_out = $urandom;
        @(posedge clk); #1;
        bus.vme_dat_wr = 1'b0;
        stray_done++;
      end else if (resp_en && bus.start === 1'b1 && rst === 1'b0 && exp_q.size() > 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        bus.vme_dat_wr      = 1'b1;
        bus.vme_dat_reg_out = exp_q[0].rdword;
        wr_cyc              = cyc;
        @(posedge clk); #1;
        bus.vme_dat_wr      = 1'b0;
        bus.vme_dat_reg_out = $urandom;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic seen;
    int   budget;
    rst = 1'b1;
    bus.req = '0; bus.req_rnw = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.vme_cmd_rd = 1'b1;
    for (int i = 0; i < NREQ; i++) fill_rand(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_start", 32'(bus.start), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_ack", 32'(bus.ack), 32'd0);
    chk("reset_cmd", bus.vme_cmd_reg, MASK);
    chk("reset_dat", bus.vme_dat_reg_in, 32'd0);
    chk("reset_rdata", 32'(bus.rdata), 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single write from requester 0.
    r_rnw[0] = 1'b0; r_addr[0] = 16'h4000; r_wdata[0] = 16'h00FF; r_rdw[0] = 32'h5555_AAAA;
    run_batch(4'b0001, 1'b0);
    chk("idle_cmd_after_write", bus.vme_cmd_reg, MASK);

    // Single read from requester 2.
    r_rnw[2] = 1'b1; r_addr[2] = 16'h1F04; r_rdw[2] = 32'h1234_ABCD;
    run_batch(4'b0100, 1'b0);
    chk("rdata_hold", 32'(bus.rdata), 32'h0000_ABCD);

    // All requesters held, then random masks.
    for (int i = 0; i < NREQ; i++) fill_rand(i);
    run_batch(4'b1111, 1'b0);
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NREQ; i++) fill_rand(i);
      run_batch(4'($urandom_range(1, 15)), 1'b0);
    end

    // Backpressure plus a stray completion strobe in IDLE.
    fill_rand(1);
    @(posedge clk); #1;
    bus.vme_cmd_rd = 1'b0;
    apply_fields();
    bus.req = 4'b0010;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.start !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    chk("backpressure_no_start", 32'(seen), 32'd0);
    stray_cnt++;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.ack !== '0) seen = 1'b1;
    end
    chk("stray_strobe_no_ack", 32'(seen), 32'd0);
    @(posedge clk); #1 bus.vme_cmd_rd = 1'b1;
    run_batch(4'b0010, 1'b0);

    // Reset during WAIT: aborted request gets no ack and the pointer returns to 0.
    fill_rand(2);
    resp_en = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(make_exp(2, 1'b0));
    apply_fields();
    bus.req = 4'b0100;
    budget = 20;
    seen = 1'b0;
    while (!seen && budget > 0) begin
      @(negedge clk);
      seen = (bus.start === 1'b1);
      budget--;
    end
    chk("abort_start_seen", 32'(seen), 32'd1);
    @(posedge clk); #1 rst = 1'b1; bus.req = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_cmd", bus.vme_cmd_reg, MASK);
    chk("abort_dat", bus.vme_dat_reg_in, 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ack", 32'(bus.ack), 32'd0);
    exp_q.delete();
    model_ptr = 0;
    resp_en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NREQ; i++) fill_rand(i);
    run_batch(4'b0101, 1'b0);

    // Watchdog: no completion strobe.
    resp_en = 1'b0;
    fill_rand(1);
`ifdef VME_ARB_TIMEOUT_EN
    run_batch(4'b0010, 1'b1);
`else
    @(posedge clk); #1;
    exp_q.push_back(make_exp(1, 1'b0));
    apply_fields();
    bus.req = 4'b0010;
    seen = 1'b0;
    repeat (5) @(negedge clk);
    repeat (60) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.ack !== '0) seen = 1'b1;
    end
    chk("no_watchdog_busy_held", 32'(seen), 32'd0);
    @(posedge clk); #1 rst = 1'b1; bus.req = '0;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    model_ptr = 0;
`endif
    resp_en = 1'b1;

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NREQ; i++) fill_rand(i);
      run_batch(4'($urandom_range(1, 15)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
